mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: icache and dcache share one RAM port.
// dcache has priority, but icache is forced through after STARVE_LIMIT consecutive dcache grants.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int WORD_W       = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              err
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } state_t;

    state_t            state_reg;
    logic [SW-1:0]     starve_cnt_reg;
    logic [WORD_W-1:0] addr_reg;
    logic [WORD_W-1:0] store_reg;
    logic              ren_reg;
    logic              wen_reg;
    logic              err_reg;
    logic              armed_reg;

    logic d_req;
    logic i_forced;
    logic grant_d;
    logic grant_i;
    logic ram_done;
    logic ram_fail;
    logic finish;
    logic i_owner;
    logic d_owner;

    always_comb begin
        d_req    = dREN | dWEN;
        i_forced = iREN && (starve_cnt_reg == STARVE_MAX);
        grant_d  = d_req && !i_forced;
        grant_i  = iREN && !grant_d;
        ram_done = (ramstate == RAM_ACCESS);
        ram_fail = (ramstate == RAM_ERROR);
        finish   = ram_done | ram_fail;
        i_owner  = (state_reg == IGNT);
        d_owner  = (state_reg == DGNT);
    end

    // armed_reg blocks arbitration on the first edge after reset is released.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= '0;
            addr_reg       <= '0;
            store_reg      <= '0;
            ren_reg        <= 1'b0;
            wen_reg        <= 1'b0;
            err_reg        <= 1'b0;
            armed_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    armed_reg <= 1'b1;
                    if (armed_reg) begin
                        if (grant_d) begin
                            state_reg <= DGNT;
                            addr_reg  <= daddr;
                            store_reg <= dstore;
                            ren_reg   <= ~dWEN;
                            wen_reg   <= dWEN;
                            if (iREN && (starve_cnt_reg != STARVE_MAX)) begin
                                starve_cnt_reg <= starve_cnt_reg + SW'(1);
                            end
                        end else if (grant_i) begin
                            state_reg      <= IGNT;
                            addr_reg       <= iaddr;
                            store_reg      <= '0;
                            ren_reg        <= 1'b1;
                            wen_reg        <= 1'b0;
                            starve_cnt_reg <= '0;
                        end
                    end
                end
                IGNT, DGNT: begin
                    // A withdrawn request does not abort; only the RAM status ends the access.
                    if (finish) begin
                        state_reg <= IDLE;
                        ren_reg   <= 1'b0;
                        wen_reg   <= 1'b0;
                        if (ram_fail) begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ren_reg   <= 1'b0;
                    wen_reg   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        iwait    = i_owner ? !finish : iREN;
        dwait    = d_owner ? !finish : d_req;
        iload    = (i_owner && ram_done) ? ramload : '0;
        dload    = (d_owner && ram_done) ? ramload : '0;
        ramREN   = ren_reg;
        ramWEN   = wen_reg;
        ramaddr  = addr_reg;
        ramstore = store_reg;
        err      = err_reg;
    end

endmodule
